// File: rtl/fpmul_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_issue_ctrl_if
// Description : Handshake bundle between the FP multiplier issue controller
//               and its requesters, result consumer and multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpmul_issue_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int LAT     = 2,
  parameter int TAG_W   = 5
);
  localparam int C_SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Requester side
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_ready;
  // Multiplier datapath control
  logic [C_SEL_W-1:0]       mul_sel;
  logic                     mul_en;
  logic [LAT-1:0]           mul_clear;
  // Kill controls
  logic                     flush_i;
  logic [LAT-1:0]           kill_stage_i;
  // Result side
  logic                     res_valid;
  logic                     res_ready;
  logic [C_SEL_W-1:0]       res_id;
  logic [TAG_W-1:0]         res_tag;
  logic                     busy;

  // Environment: requesters, consumer and pipeline killer
  modport master (
    output req_valid, req_tag, flush_i, kill_stage_i, res_ready,
    input  req_ready, mul_sel, mul_en, mul_clear, res_valid, res_id, res_tag, busy
  );

  // Issue controller
  modport slave (
    input  req_valid, req_tag, flush_i, kill_stage_i, res_ready,
    output req_ready, mul_sel, mul_en, mul_clear, res_valid, res_id, res_tag, busy
  );
endinterface
`default_nettype wire

// File: rtl/fpmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_issue_ctrl
// Description : Round-robin issue controller for a LAT-stage pipelined FP
//               multiplier. Tracks per-stage valid/id/tag, drives the
//               multiplier enable and per-stage clears, and returns results
//               with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fpmul_issue_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int LAT     = 2,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  fpmul_issue_ctrl_if.slave bus
);
  localparam int C_SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Pipeline occupancy and per-stage bookkeeping (index 0 = first stage)
  logic [LAT-1:0]     v_q, v_d;
  logic [C_SEL_W-1:0] id_q  [LAT];
  logic [C_SEL_W-1:0] id_d  [LAT];
  logic [TAG_W-1:0]   tag_q [LAT];
  logic [TAG_W-1:0]   tag_d [LAT];
  logic [C_SEL_W-1:0] ptr_q, ptr_d;
  logic [C_SEL_W-1:0] sel_q, sel_d;

  logic               w_mul_en;
  logic               w_grant_any;
  logic [C_SEL_W-1:0] w_gnt_idx;
  logic [C_SEL_W:0]   w_sum;
  logic [C_SEL_W-1:0] w_cand;
  logic [TAG_W-1:0]   w_req_tag [NUM_REQ];
  logic [LAT-1:0]     w_mul_clear;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack_tag
    assign w_req_tag[gi] = bus.req_tag[gi*TAG_W +: TAG_W];
  end

  // The whole pipe freezes while an unaccepted result sits in the last stage
  assign w_mul_en      = !(v_q[LAT-1] && !bus.res_ready);
  assign bus.mul_en    = w_mul_en;
  assign bus.res_valid = v_q[LAT-1] && !bus.kill_stage_i[LAT-1] && !bus.flush_i;
  assign bus.res_id    = id_q[LAT-1];
  assign bus.res_tag   = tag_q[LAT-1];
  assign bus.busy      = |v_q;
  assign bus.mul_clear = w_mul_clear;
  assign bus.req_ready = w_grant_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign bus.mul_sel   = w_grant_any ? w_gnt_idx : sel_q;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ
  always_comb begin
    w_grant_any = 1'b0;
    w_gnt_idx   = '0;
    w_sum       = '0;
    w_cand      = '0;
    if (w_mul_en && !bus.flush_i) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        w_sum = {1'b0, ptr_q} + (C_SEL_W+1)'(j);
        if (w_sum >= (C_SEL_W+1)'(NUM_REQ)) begin
          w_sum = w_sum - (C_SEL_W+1)'(NUM_REQ);
        end
        w_cand = w_sum[C_SEL_W-1:0];
        if (!w_grant_any && bus.req_valid[w_cand]) begin
          w_grant_any = 1'b1;
          w_gnt_idx   = w_cand;
        end
      end
    end
  end

  // Next-state for stage tracking, pointer and per-stage clears
  always_comb begin
    v_d         = v_q;
    id_d        = id_q;
    tag_d       = tag_q;
    ptr_d       = ptr_q;
    sel_d       = bus.mul_sel;
    w_mul_clear = '0;
    if (bus.flush_i) begin
      // Flush beats both stall and kill: every stage register is zeroed
      v_d         = '0;
      w_mul_clear = '1;
    end else if (w_mul_en) begin
      v_d[0]   = w_grant_any;
      id_d[0]  = w_gnt_idx;
      tag_d[0] = w_req_tag[w_gnt_idx];
      for (int k = 0; k < LAT-1; k++) begin
        v_d[k+1]   = v_q[k] && !bus.kill_stage_i[k];
        id_d[k+1]  = id_q[k];
        tag_d[k+1] = tag_q[k];
        // A killed op moves into stage k+1, so that register is the one zeroed
        if (bus.kill_stage_i[k]) begin
          w_mul_clear[LAT-2-k] = 1'b1;
        end
      end
      if (w_grant_any) begin
        ptr_d = (w_gnt_idx == C_SEL_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end else begin
      // Stalled: killed ops stay put, so clear their own stage register
      for (int k = 0; k < LAT; k++) begin
        if (bus.kill_stage_i[k]) begin
          v_d[k]             = 1'b0;
          w_mul_clear[LAT-1-k] = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      ptr_q <= '0;
      sel_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        id_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      id_q  <= id_d;
      tag_q <= tag_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fpmul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmul_issue_ctrl
// Description : Self-checking bench for fpmul_issue_ctrl with a queue-based
//               reference model of in-flight multiplier operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmul_issue_ctrl;
  localparam int NUM_REQ = 2;
  localparam int LAT     = 2;
  localparam int TAG_W   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpmul_issue_ctrl_if #(.NUM_REQ(NUM_REQ), .LAT(LAT), .TAG_W(TAG_W)) bus ();

  fpmul_issue_ctrl #(.NUM_REQ(NUM_REQ), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One record per operation in flight; stage counts from 0 at issue
  typedef struct {
    int id;
    int tag;
    int stage;
  } op_t;

  op_t pipe[$];
  int  ptr;

  task automatic model_reset();
    pipe.delete();
    ptr = 0;
  endtask

  task automatic drive_idle();
    bus.req_valid    = '0;
    bus.req_tag      = '0;
    bus.res_ready    = 1'b1;
    bus.kill_stage_i = '0;
    bus.flush_i      = 1'b0;
  endtask

  // Called at a negedge: drive, check outputs against the model, advance model
  task automatic run_cycle(input logic [NUM_REQ-1:0] rv, input logic rr,
                           input logic [LAT-1:0] kill, input logic flush);
    int   tags [NUM_REQ];
    logic [NUM_REQ*TAG_W-1:0] ptags;
    int   fin;
    bit   exp_en;
    bit   exp_rv;
    int   gi;
    int   idx;
    int   exp_ready;
    int   exp_clr;
    op_t  nq[$];
    op_t  op;

    for (int i = 0; i < NUM_REQ; i++) begin
      tags[i] = $urandom_range(0, (1 << TAG_W) - 1);
      ptags[i*TAG_W +: TAG_W] = TAG_W'(tags[i]);
    end
    bus.req_valid    = rv;
    bus.req_tag      = ptags;
    bus.res_ready    = rr;
    bus.kill_stage_i = kill;
    bus.flush_i      = flush;
    #1;

    fin = -1;
    foreach (pipe[q]) if (pipe[q].stage == LAT-1) fin = q;
    exp_en = !(fin >= 0 && !rr);
    exp_rv = (fin >= 0) && !kill[LAT-1] && !flush;
    gi = -1;
    if (exp_en && !flush) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        idx = (ptr + j) % NUM_REQ;
        if (gi < 0 && rv[idx]) gi = idx;
      end
    end
    exp_ready = (gi >= 0) ? (1 << gi) : 0;
    exp_clr = 0;
    if (flush) begin
      exp_clr = (1 << LAT) - 1;
    end else if (!exp_en) begin
      for (int k = 0; k < LAT; k++) if (kill[k]) exp_clr |= 1 << (LAT-1-k);
    end else begin
      for (int k = 0; k < LAT-1; k++) if (kill[k]) exp_clr |= 1 << (LAT-2-k);
    end

    check_eq("mul_en", 32'(bus.mul_en), 32'(exp_en));
    check_eq("req_ready", 32'(bus.req_ready), exp_ready);
    check_eq("mul_clear", 32'(bus.mul_clear), exp_clr);
    check_eq("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    check_eq("busy", 32'(bus.busy), 32'(pipe.size() != 0));
    if (gi >= 0) check_eq("mul_sel", 32'(bus.mul_sel), gi);
    if (exp_rv) begin
      check_eq("res_id", 32'(bus.res_id), pipe[fin].id);
      check_eq("res_tag", 32'(bus.res_tag), pipe[fin].tag);
    end

    if (flush) begin
      pipe.delete();
    end else if (!exp_en) begin
      foreach (pipe[q]) if (!kill[pipe[q].stage]) nq.push_back(pipe[q]);
      pipe = nq;
    end else begin
      foreach (pipe[q]) begin
        if (pipe[q].stage != LAT-1 && !kill[pipe[q].stage]) begin
          op = pipe[q];
          op.stage++;
          nq.push_back(op);
        end
      end
      if (gi >= 0) begin
        op = '{gi, tags[gi], 0};
        nq.push_back(op);
        ptr = (gi + 1) % NUM_REQ;
      end
      pipe = nq;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #12;
    check_eq("rst_res_valid", 32'(bus.res_valid), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 0);
    check_eq("rst_mul_clear", 32'(bus.mul_clear), 0);
    check_eq("rst_mul_en", 32'(bus.mul_en), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single op from requester 0, then drain
    run_cycle(2'b01, 1'b1, '0, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(2'b00, 1'b1, '0, 1'b0);

    // Round-robin with both requesters valid
    for (int c = 0; c < 6; c++) run_cycle(2'b11, 1'b1, '0, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(2'b00, 1'b1, '0, 1'b0);

    // Back-pressure: fill, stall four cycles, then drain
    for (int c = 0; c < 2; c++) run_cycle(2'b11, 1'b1, '0, 1'b0);
    for (int c = 0; c < 4; c++) run_cycle(2'b11, 1'b0, '0, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(2'b00, 1'b1, '0, 1'b0);

    // Kill of stage 0 while advancing
    run_cycle(2'b11, 1'b1, '0, 1'b0);
    run_cycle(2'b11, 1'b1, 2'b01, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(2'b00, 1'b1, '0, 1'b0);

    // Stall combined with a kill of the final stage
    for (int c = 0; c < 2; c++) run_cycle(2'b11, 1'b1, '0, 1'b0);
    run_cycle(2'b11, 1'b0, 2'b10, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle(2'b00, 1'b1, '0, 1'b0);

    // Flush with ops in flight and both requesters pending
    for (int c = 0; c < 2; c++) run_cycle(2'b11, 1'b1, '0, 1'b0);
    run_cycle(2'b11, 1'b1, '0, 1'b1);
    for (int c = 0; c < 3; c++) run_cycle(2'b11, 1'b1, '0, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [LAT-1:0] kl;
      for (int k = 0; k < LAT; k++) kl[k] = ($urandom_range(0, 11) == 0);
      run_cycle(NUM_REQ'($urandom), ($urandom_range(0, 9) < 7), kl,
                ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset between edges with ops in flight
    for (int c = 0; c < 2; c++) run_cycle(2'b11, 1'b1, '0, 1'b0);
    drive_idle();
    bus.res_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("arst_res_valid", 32'(bus.res_valid), 0);
    check_eq("arst_busy", 32'(bus.busy), 0);
    #2;
    rst = 1'b0;
    model_reset();
    run_cycle(2'b11, 1'b1, '0, 1'b0);
    for (int c = 0; c < 4; c++) run_cycle(2'b00, 1'b1, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
